test_sequencer: RTL and testbench
=================================

# test_sequencer

Drives a chain of staged self-checking blocks. Each stage has a start/finish handshake. Stages are released in order with a cumulative (thermometer) start vector. The block detects each stage's finish, counts total elapsed cycles, and flags the first stage that stalls. It sits directly upstream of the test chain: its `stage_start` bits feed each stage's start input, and each stage's finish output returns on `stage_finish`.

## Interface
- `N_STAGES`, 15, number of chained stages (≥2)
- `TIMEOUT_CYCLES`, 100000, per-stage watchdog limit in cycles (≥2)
- `clk  input  1  single clock, rising edge`
- `rst_n  input  1  asynchronous, active-low reset`
- `go  input  1  start or restart request, sampled each cycle`
- `abort  input  1  synchronous return to IDLE`
- `stage_finish  input  N_STAGES  level finish flag per stage`
- `stage_start  output  N_STAGES  thermometer start vector; bit i feeds stage i`
- `busy  output  1  high in RUN`
- `done  output  1  high in DONE`
- `pass  output  1  high in DONE only`
- `timeout  output  1  high in FAIL only`
- `fail_stage  output  $clog2(N_STAGES)  index of the stalled stage, valid in FAIL`
- `total_cycles  output  32  RUN cycles since last go; saturates at 0xFFFF_FFFF`

## Operation
- States are IDLE, RUN, DONE and FAIL. `cur` is the current stage index.
- Reset values: state IDLE; `stage_start`, `cur`, `fail_stage`, `total_cycles` and the watchdog all 0; `busy`, `done`, `pass` and `timeout` all 0.
- **IDLE**
  - `go=1` → RUN, `cur=0`, `stage_start=1`, `total_cycles=0`, watchdog cleared.
- **RUN**
  - `total_cycles` increments each cycle.
  - `stage_finish[cur]=1` and `cur<N_STAGES-1` → `cur+1`, set `stage_start[cur+1]`, clear the watchdog.
  - `stage_finish[cur]=1` and `cur=N_STAGES-1` → DONE.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT_CYCLES-1` without a finish → FAIL, `fail_stage=cur`.
  - Finish bits of stages other than `cur` are ignored.
  - `go` is ignored.
- **DONE / FAIL**
  - `stage_start` holds its value; counters freeze.
  - `go=1` restarts exactly as from IDLE: vector becomes `1`, `cur=0`.
- **abort=1** in any state → IDLE next cycle, with `stage_start` and counters cleared.
- **Simultaneous events**
  - `abort` beats `go`.
  - A finish beats a watchdog expiry in the same cycle.
- `stage_start` bits are never cleared except by reset, `abort` or `go`. Once released, a stage's start stays high.
- An asynchronous `rst_n` assertion mid-RUN returns everything to reset values immediately.

## Timing
- All outputs are registered.
- `go` at edge k → `stage_start[0]` and `busy` high after edge k.
- `stage_finish[i]` high at edge k → `stage_start[i+1]` high after edge k. Handoff latency is 1 cycle.
- A finish bit already high when its stage is entered counts on the first RUN cycle of that stage. Minimum stage dwell is 1 cycle.
- Timeout asserts exactly `TIMEOUT_CYCLES` cycles after stage entry if no finish arrives.

## Configuration
- `TEST_SEQ_TIMEOUT_EN` defined: the watchdog is built and FAIL is reachable as above.
- `TEST_SEQ_TIMEOUT_EN` undefined: no watchdog logic is built, RUN waits indefinitely, and `timeout`, `fail_stage` and FAIL are tied off at their reset values. `TIMEOUT_CYCLES` is unused.

## Structure
- Package `test_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE, FAIL);
  - the default `TIMEOUT_CYCLES`;
  - the `total_cycles` width constant (32).
- One sub-module, `test_seq_watchdog`. It is a loadable counter with clear and enable inputs and a single-cycle `expired` output. It is instantiated only under `TEST_SEQ_TIMEOUT_EN`.

## Test plan
- **Reset:** hold `rst_n=0` → all outputs 0, state IDLE. Release with `go=0` → stays IDLE.
- **Full pass:** `N_STAGES=4`; pulse `go`, and each stage raises finish 3 cycles after its start.
  - `stage_start` steps 0001→0011→0111→1111.
  - `done=pass=1`; `total_cycles=16`.
- **Timeout:** `TIMEOUT_CYCLES=10`; stage 2 never finishes → `timeout=1`, `fail_stage=2`, `stage_start=0111`. FAIL is entered 10 cycles after stage 2's entry.
- **Race:** stage 1 finish and watchdog expiry in the same cycle → advances to stage 2, no FAIL.
- **Abort and go together:** assert both mid-RUN → IDLE, `stage_start=0`. A following `go` restarts with `stage_start=0001`.
- **Pre-asserted finish:** all `stage_finish` tied high → one stage per cycle, DONE after 4 RUN cycles, `total_cycles=4`.

Source files
------------

// File: rtl/test_seq_pkg.sv
// Shared types and constants for the staged test sequencer.
package test_seq_pkg;

  // Sequencer states: waiting, stepping through stages, all passed, stage stalled.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  // Default number of chained stages.
  localparam int N_STAGES_DEF = 15;

  // Default per-stage watchdog limit in cycles.
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;

  // Width of the elapsed-cycle counter.
  localparam int TOTAL_W = 32;

endpackage

// File: rtl/test_seq_if.sv
// Handshake bundle between the sequencer and the chain of staged test blocks.
// master: the sequencer. slave: the chain / host driving go, abort, finish.
interface test_seq_if #(
  parameter int N_STAGES = 15
) ();
  import test_seq_pkg::*;

  localparam int IDX_W = $clog2(N_STAGES);

  logic                go;
  logic                abort;
  logic [N_STAGES-1:0] stage_finish;
  logic [N_STAGES-1:0] stage_start;
  logic                busy;
  logic                done;
  logic                pass;
  logic                timeout;
  logic [IDX_W-1:0]    fail_stage;
  logic [TOTAL_W-1:0]  total_cycles;

  modport master (
    input  go, abort, stage_finish,
    output stage_start, busy, done, pass, timeout, fail_stage, total_cycles
  );

  modport slave (
    output go, abort, stage_finish,
    input  stage_start, busy, done, pass, timeout, fail_stage, total_cycles
  );

endinterface

// File: rtl/test_seq_watchdog.sv
// Per-stage watchdog: a loadable down-counter holding the cycles left in the
// current stage. expired_o is high for the one enabled cycle in which the
// count has run out; the sequencer leaves RUN on it, so it never repeats.
module test_seq_watchdog #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;

  // Counter: clear beats load beats count-down; holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state is always written with <= so every flop samples
      // the pre-edge values of its neighbours; = here would create races.
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/test_sequencer.sv
// Staged test sequencer: releases stages with a cumulative start vector,
// advances on the current stage's finish, counts RUN cycles and, when the
// TEST_SEQ_TIMEOUT_EN macro is defined, flags the first stage that stalls.
// Without TEST_SEQ_TIMEOUT_EN no watchdog is built and FAIL is unreachable.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int          N_STAGES       = N_STAGES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic        clk,
  input logic        rst_n,
  test_seq_if.master tsq
);

  localparam int CUR_W = $clog2(N_STAGES);
  localparam logic [CUR_W-1:0]    LAST_STAGE  = CUR_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] START_FIRST = N_STAGES'(1);

  state_e               state_q, state_d;
  logic [CUR_W-1:0]     cur_q, cur_d;
  logic [N_STAGES-1:0]  start_q, start_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic                 busy_q, done_q, pass_q;

`ifdef TEST_SEQ_TIMEOUT_EN
  logic [CUR_W-1:0]     fail_q, fail_d;
  logic                 timeout_q;
  logic                 wd_clr, wd_load, wd_en, wd_expired;

  test_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .load_i    (wd_load),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );
`endif

  // Next-state logic: abort wins, then go from a resting state, then RUN stepping.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    start_d = start_q;
    total_d = total_q;
`ifdef TEST_SEQ_TIMEOUT_EN
    fail_d  = fail_q;
    wd_clr  = 1'b0;
    wd_load = 1'b0;
    wd_en   = 1'b0;
`endif
    if (tsq.abort) begin
      state_d = ST_IDLE;
      cur_d   = '0;
      start_d = '0;
      total_d = '0;
`ifdef TEST_SEQ_TIMEOUT_EN
      fail_d  = '0;
      wd_clr  = 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_RUN: begin
          total_d = (total_q == '1) ? total_q : total_q + 1'b1;
          if (tsq.stage_finish[cur_q]) begin
            // A finish beats a same-cycle watchdog expiry.
            if (cur_q == LAST_STAGE) begin
              state_d = ST_DONE;
            end else begin
              cur_d   = cur_q + 1'b1;
              // Vector is a thermometer, so shifting in a 1 releases stage cur+1.
              start_d = {start_q[N_STAGES-2:0], 1'b1};
`ifdef TEST_SEQ_TIMEOUT_EN
              wd_load = 1'b1;
`endif
            end
          end
`ifdef TEST_SEQ_TIMEOUT_EN
          else begin
            wd_en = 1'b1;
            if (wd_expired) begin
              state_d = ST_FAIL;
              fail_d  = cur_q;
            end
          end
`endif
        end
        default: begin
          // IDLE, DONE and FAIL all restart identically on go.
          if (tsq.go) begin
            state_d = ST_RUN;
            cur_d   = '0;
            start_d = START_FIRST;
            total_d = '0;
`ifdef TEST_SEQ_TIMEOUT_EN
            fail_d  = '0;
            wd_load = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      start_q   <= '0;
      total_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
`ifdef TEST_SEQ_TIMEOUT_EN
      fail_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      start_q   <= start_d;
      total_q   <= total_d;
      busy_q    <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      pass_q    <= (state_d == ST_DONE);
`ifdef TEST_SEQ_TIMEOUT_EN
      fail_q    <= fail_d;
      timeout_q <= (state_d == ST_FAIL);
`endif
    end
  end

  assign tsq.stage_start  = start_q;
  assign tsq.total_cycles = total_q;
  assign tsq.busy         = busy_q;
  assign tsq.done         = done_q;
  assign tsq.pass         = pass_q;
`ifdef TEST_SEQ_TIMEOUT_EN
  assign tsq.timeout      = timeout_q;
  assign tsq.fail_stage   = fail_q;
`else
  assign tsq.timeout      = 1'b0;
  assign tsq.fail_stage   = '0;
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer with 4 stages and a 10-cycle watchdog. Each stage is
// emulated as a block that raises finish a set delay after its start rises
// (delay 0 = finish tied high). Expected timing comes from per-stage dwell
// arithmetic. Expectations follow the TEST_SEQ_TIMEOUT_EN build setting.
module tb_test_sequencer;
  import test_seq_pkg::*;

  localparam int NS  = 4;
  localparam int TMO = 10;
`ifdef TEST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef logic [NS-1:0][7:0] dly_t;

  // Outcome of one run derived from the dwell times.
  typedef struct packed {
    logic [31:0]         end_c;   // edge (after go) at which DONE/FAIL is entered
    logic                fail;
    logic [31:0]         fidx;
    logic [NS-1:0][31:0] enter;   // edge at which each stage is released
  } model_t;

  // Directed vector: stage delays plus hand-computed final outcome.
  typedef struct packed {
    dly_t        d;
    logic        exp_fail;
    logic [1:0]  exp_fidx;
    logic [31:0] exp_total;
    logic [NS-1:0] exp_start;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  test_seq_if #(.N_STAGES(NS)) tsq ();

  test_sequencer #(
    .N_STAGES       (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tsq   (tsq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic model_t model(input dly_t d);
    model_t m;
    int k;
    m = '0;
    for (int i = 0; i < NS; i++) m.enter[i] = 32'hFFFF_FFFF;
    m.enter[0] = 0;
    for (int i = 0; i < NS; i++) begin
      k = int'(d[i]) + 1;  // finish seen on the (delay+1)-th edge after release
      if (TO_EN && k > TMO) begin
        m.fail  = 1'b1;
        m.fidx  = i;
        m.end_c = m.enter[i] + TMO;
        break;
      end
      if (i == NS - 1) m.end_c = m.enter[i] + k;
      else m.enter[i+1] = m.enter[i] + k;
    end
    return m;
  endfunction

  function automatic logic [NS-1:0] therm(input model_t m, input int c);
    logic [NS-1:0] r = '0;
    for (int i = 0; i < NS; i++) if (m.enter[i] <= 32'(c)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(input dly_t d, input logic f, input int fi, input int tot,
                              input logic [NS-1:0] st);
    vec_t v;
    v.d = d; v.exp_fail = f; v.exp_fidx = 2'(fi); v.exp_total = 32'(tot); v.exp_start = st;
    return v;
  endfunction

  // One full run from go to DONE/FAIL with per-cycle checks against the model.
  task automatic run_chain(input dly_t d, input bit go_noise, output model_t m);
    int  age [NS];
    bit  started [NS];
    logic [NS-1:0] fin_now;
    m = model(d);
    for (int i = 0; i < NS; i++) begin
      age[i] = 0;
      started[i] = 1'b0;
      fin_now[i] = (d[i] == 0);
    end
    tsq.abort = 1'b0;
    tsq.stage_finish = fin_now;
    tsq.go = 1'b1;
    step();
    tsq.go = 1'b0;
    for (int c = 0; c <= int'(m.end_c); c++) begin
      check("stage_start", 32'(tsq.stage_start), 32'(therm(m, c)));
      check("busy", 32'(tsq.busy), 32'(c < int'(m.end_c)));
      check("done", 32'(tsq.done), 32'(c == int'(m.end_c) && !m.fail));
      check("timeout", 32'(tsq.timeout), 32'(c == int'(m.end_c) && m.fail));
      check("total_cycles", tsq.total_cycles, 32'(c));
      if (c == int'(m.end_c)) break;
      for (int i = 0; i < NS; i++) begin
        if (tsq.stage_start[i]) begin
          if (started[i]) age[i]++;
          else begin started[i] = 1'b1; age[i] = 0; end
        end
        fin_now[i] = (d[i] == 0) || (started[i] && age[i] >= int'(d[i]));
      end
      tsq.stage_finish = fin_now;
      tsq.go = go_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    tsq.go = 1'b0;
    check("pass", 32'(tsq.pass), 32'(!m.fail));
    if (m.fail) check("fail_stage", 32'(tsq.fail_stage), m.fidx);
    // Outputs and counters hold in DONE/FAIL.
    repeat (2) step();
    check("frozen_total", tsq.total_cycles, m.end_c);
    check("frozen_start", 32'(tsq.stage_start), 32'(therm(m, int'(m.end_c))));
    check("frozen_busy", 32'(tsq.busy), 32'(0));
  endtask

  vec_t   tbl [8];
  model_t m;
  dly_t   rd;

  initial begin
    tsq.go = 1'b0;
    tsq.abort = 1'b0;
    tsq.stage_finish = '0;

    // Hand-computed outcomes: dwell per stage is delay+1 edges.
    tbl[0] = mk({8'd3, 8'd3, 8'd3, 8'd3}, 0, 0, 16, 4'b1111);
    tbl[1] = mk({8'd0, 8'd0, 8'd0, 8'd0}, 0, 0, 4, 4'b1111);
    tbl[3] = mk({8'd0, 8'd0, 8'd9, 8'd0}, 0, 0, 13, 4'b1111);  // stage 1 finish on expiry edge
    tbl[5] = mk({8'd9, 8'd9, 8'd9, 8'd9}, 0, 0, 40, 4'b1111);
    tbl[6] = mk({8'd5, 8'd0, 8'd2, 8'd1}, 0, 0, 12, 4'b1111);
`ifdef TEST_SEQ_TIMEOUT_EN
    tbl[2] = mk({8'd0, 8'd20, 8'd3, 8'd3}, 1, 2, 18, 4'b0111);
    tbl[4] = mk({8'd0, 8'd0, 8'd0, 8'd10}, 1, 0, 10, 4'b0001);
    tbl[7] = mk({8'd20, 8'd0, 8'd0, 8'd0}, 1, 3, 13, 4'b1111);
`else
    tbl[2] = mk({8'd0, 8'd20, 8'd3, 8'd3}, 0, 0, 30, 4'b1111);
    tbl[4] = mk({8'd0, 8'd0, 8'd0, 8'd10}, 0, 0, 14, 4'b1111);
    tbl[7] = mk({8'd20, 8'd0, 8'd0, 8'd0}, 0, 0, 24, 4'b1111);
`endif

    // Reset: everything low while held, stays idle after release with go=0.
    repeat (2) step();
    check("rst_busy", 32'(tsq.busy), 32'(0));
    check("rst_done", 32'(tsq.done), 32'(0));
    check("rst_pass", 32'(tsq.pass), 32'(0));
    check("rst_timeout", 32'(tsq.timeout), 32'(0));
    check("rst_start", 32'(tsq.stage_start), 32'(0));
    check("rst_fail_stage", 32'(tsq.fail_stage), 32'(0));
    check("rst_total", tsq.total_cycles, 32'(0));
    #2 rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", 32'(tsq.busy), 32'(0));
    check("idle_start", 32'(tsq.stage_start), 32'(0));

    // Directed table; each run restarts straight from the previous DONE/FAIL.
    for (int r = 0; r < 8; r++) begin
      run_chain(tbl[r].d, 1'b0, m);
      check($sformatf("tbl%0d_total", r), tsq.total_cycles, tbl[r].exp_total);
      check($sformatf("tbl%0d_start", r), 32'(tsq.stage_start), 32'(tbl[r].exp_start));
      check($sformatf("tbl%0d_timeout", r), 32'(tsq.timeout), 32'(tbl[r].exp_fail));
      if (tbl[r].exp_fail)
        check($sformatf("tbl%0d_fail_stage", r), 32'(tsq.fail_stage), 32'(tbl[r].exp_fidx));
    end

    // abort and go together mid-RUN: abort wins, then a lone go restarts.
    tsq.stage_finish = '0;
    tsq.go = 1'b1;
    step();
    tsq.go = 1'b0;
    repeat (4) step();
    check("mid_busy", 32'(tsq.busy), 32'(1));
    check("mid_start", 32'(tsq.stage_start), 32'(1));
    tsq.abort = 1'b1;
    tsq.go = 1'b1;
    step();
    check("abort_busy", 32'(tsq.busy), 32'(0));
    check("abort_start", 32'(tsq.stage_start), 32'(0));
    check("abort_total", tsq.total_cycles, 32'(0));
    tsq.abort = 1'b0;
    step();
    tsq.go = 1'b0;
    check("rego_start", 32'(tsq.stage_start), 32'(1));
    check("rego_busy", 32'(tsq.busy), 32'(1));
    check("rego_total", tsq.total_cycles, 32'(0));
    step();
    check("rego_total1", tsq.total_cycles, 32'(1));

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(tsq.busy), 32'(0));
    check("async_start", 32'(tsq.stage_start), 32'(0));
    check("async_total", tsq.total_cycles, 32'(0));
    step();
    #2 rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(tsq.busy), 32'(0));

    // Randomised runs with go noise during RUN (must be ignored).
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NS; i++)
        rd[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 11)) : 8'($urandom_range(0, 4));
      run_chain(rd, 1'b1, m);
    end

    // abort from a resting state returns to IDLE.
    tsq.abort = 1'b1;
    step();
    tsq.abort = 1'b0;
    check("abort_rest_done", 32'(tsq.done), 32'(0));
    check("abort_rest_pass", 32'(tsq.pass), 32'(0));
    check("abort_rest_timeout", 32'(tsq.timeout), 32'(0));
    check("abort_rest_start", 32'(tsq.stage_start), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
